flag_unit: RTL

- Producer side of the {N,O,Z} flag bus consumed by pc_control's `f` input.
- Computes candidate flags from the EX-stage ALU result and masks them per opcode.
- Holds the architectural flag register and delivers the flags seen by a branch in ID.
- Sits between the ALU (EX) and pc_control (ID); handles pipeline stall and flush.

---
 rtl/cpu_pkg.sv | 62 ++++++
 rtl/flag_mask_dec.sv | 23 ++
 rtl/flag_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the flag producer, pc_control and the hazard unit.
//   opcode_e      4-bit ALU/control opcode encoding
//   cond_e        3-bit branch condition code, consumed by pc_control
//   flags_t       {N,O,Z} flag vector, bit positions given by FLAG_N/FLAG_O/FLAG_Z
//   opcode_mask() which flags an opcode is allowed to update
package cpu_pkg;

  typedef enum logic [3:0] {
    OpAdd    = 4'h0,
    OpSub    = 4'h1,
    OpXor    = 4'h2,
    OpRed    = 4'h3,
    OpSll    = 4'h4,
    OpSra    = 4'h5,
    OpRor    = 4'h6,
    OpPaddsb = 4'h7,
    OpLw     = 4'h8,
    OpSw     = 4'h9,
    OpLlb    = 4'hA,
    OpLhb    = 4'hB,
    OpB      = 4'hC,
    OpBr     = 4'hD,
    OpPcs    = 4'hE,
    OpHlt    = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    CondBne = 3'd0,
    CondBeq = 3'd1,
    CondBgt = 3'd2,
    CondBlt = 3'd3,
    CondBge = 3'd4,
    CondBle = 3'd5,
    CondBov = 3'd6,
    CondUcd = 3'd7
  } cond_e;

  localparam int unsigned FlagW  = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_O = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef logic [FlagW-1:0] flags_t;

  localparam flags_t MaskAll  = 3'b111;
  localparam flags_t MaskZ    = 3'b001;
  localparam flags_t MaskNone = 3'b000;

  // Arithmetic ops own all three flags; logical/shift ops only define Z.
  // Everything else, including unknown encodings, leaves the flags alone.
  function automatic flags_t opcode_mask(logic [3:0] op);
    flags_t m;
    m = MaskNone;
    case (op)
      OpAdd, OpSub:               m = MaskAll;
      OpXor, OpSll, OpSra, OpRor: m = MaskZ;
      default:                    m = MaskNone;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/flag_mask_dec.sv
// flag_mask_dec: opcode -> flag update mask, purely combinational.
// Also instantiated by the hazard unit, so it carries no state.
//   opcode_i  [OPW-1:0]  opcode of the instruction being decoded
//   mask_o    [2:0]      per-flag write enable, bit order {N,O,Z}
module flag_mask_dec
  import cpu_pkg::*;
#(
  parameter int unsigned OPW = 4
) (
  input  logic [OPW-1:0] opcode_i,
  output flags_t         mask_o
);

  // The opcode map is 4 bits wide; wider buses are truncated to it.
  logic [3:0] op;
  assign op = 4'(opcode_i);

  always_comb begin
    mask_o = MaskNone;
    mask_o = opcode_mask(op);
  end

endmodule

// File: rtl/flag_unit.sv
// flag_unit: producer of the {N,O,Z} flag bus read by pc_control.
// Derives candidate flags from the EX-stage ALU result, masks them by opcode,
// holds the architectural flag register and presents the flags seen by a
// branch sitting in ID.
//
// Build option FLAG_FWD_EN:
//   defined   - flags being written by the live EX instruction are forwarded to f,
//               flag_hazard is tied low.
//   undefined - f is the registered value; flag_hazard asks the hazard unit to hold
//               a branch in ID for one cycle while an EX flag write is in flight.
//   Both builds produce the same f_reg sequence.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   ex_valid     EX holds a live instruction
//   ex_opcode    EX opcode
//   ex_result    EX ALU result
//   ex_ovf       signed overflow from the ALU adder
//   stall        pipeline freeze, EX does not retire
//   flush        squash the EX instruction
//   id_branch    ID holds a conditional branch
//   f            flags to pc_control {N,O,Z}
//   f_reg        architectural flag register {N,O,Z}
//   flag_hazard  stall request for the branch in ID
module flag_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DW  = 16,
  parameter int unsigned OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ex_valid,
  input  logic [OPW-1:0] ex_opcode,
  input  logic [DW-1:0]  ex_result,
  input  logic           ex_ovf,
  input  logic           stall,
  input  logic           flush,
  input  logic           id_branch,
  output logic [2:0]     f,
  output logic [2:0]     f_reg,
  output logic           flag_hazard
);

  flags_t mask;
  flags_t cand;
  flags_t merged;
  flags_t f_reg_q;
  flags_t f_reg_d;
  logic   wr;
  logic   ex_writes;

  flag_mask_dec #(
    .OPW (OPW)
  ) u_mask_dec (
    .opcode_i (ex_opcode),
    .mask_o   (mask)
  );

  always_comb begin
    cand         = '0;
    cand[FLAG_Z] = (ex_result == '0);
    cand[FLAG_N] = ex_result[DW-1];
    cand[FLAG_O] = ex_ovf;
  end

  // Unmasked bits keep their previous value, so a Z-only writer after an
  // arithmetic op leaves that op's N and O in place.
  assign merged = (f_reg_q & ~mask) | (cand & mask);

  // A live, unsquashed instruction that touches at least one flag. Stall is
  // deliberately absent: a stalled EX is still going to write, just later.
  assign ex_writes = ex_valid & ~flush & (mask != MaskNone);

  assign wr = ex_valid & ~stall & ~flush & ~rst;

  always_comb begin
    f_reg_d = f_reg_q;
    if (wr) begin
      f_reg_d = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_reg_q <= '0;
    end else begin
      f_reg_q <= f_reg_d;
    end
  end

  assign f_reg = f_reg_q;

`ifdef FLAG_FWD_EN
  // EX content is stable under stall, so forwarding stays correct while frozen.
  logic unused_id_branch;
  assign unused_id_branch = id_branch;

  always_comb begin
    f           = '0;
    flag_hazard = 1'b0;
    if (!rst) begin
      f = ex_writes ? merged : f_reg_q;
    end
  end
`else
  always_comb begin
    f           = '0;
    flag_hazard = 1'b0;
    if (!rst) begin
      f           = f_reg_q;
      flag_hazard = id_branch & ex_writes;
    end
  end
`endif

endmodule
